// File: rtl/buzzer_scheduler.sv
// Buzzer scheduler: fixed-priority arbitration between three alert sources
// and sequencing of each granted alert as a burst of timed beeps followed
// by a silent gap. All durations are counted in FSM ticks.
module buzzer_scheduler #(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 6
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] Req,
    input  logic [5:0] ReqTone,
    input  logic [5:0] ReqCnt,
    output logic [1:0] Bu,
    output logic       Busy,
    output logic [2:0] Grant,
    output logic [2:0] Pend
);

    localparam int MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_T = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
    localparam int TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // A requested count of zero still produces one beep.
    function automatic logic [1:0] map_cnt(input logic [1:0] c);
        return (c == 2'b00) ? 2'b01 : c;
    endfunction

    state_t        state_r, state_s;
    logic [TW-1:0] tick_r, tick_s;
    logic [1:0]    beeps_r, beeps_s;
    logic [1:0]    tone_r, tone_s;
    logic [2:0]    pend_r, pend_s;
    logic [2:0]    grant_r, grant_s;
    logic [1:0]    bu_r, bu_s;
    logic          busy_r, busy_s;
    logic [1:0]    slot_tone_r [3];
    logic [1:0]    slot_cnt_r  [3];
    logic [1:0]    pick_s;
    logic [1:0]    pick_tone_s;
    logic [1:0]    pick_cnt_s;

    // Fixed priority: lowest pending index wins, and fetch that slot's values.
    always_comb begin
        pick_s      = 2'd0;
        pick_tone_s = 2'b00;
        pick_cnt_s  = 2'b01;
        if (pend_r[0]) begin
            pick_s = 2'd0;
        end else if (pend_r[1]) begin
            pick_s = 2'd1;
        end else if (pend_r[2]) begin
            pick_s = 2'd2;
        end else begin
            pick_s = 2'd0;
        end
        case (pick_s)
            2'd0: begin
                pick_tone_s = slot_tone_r[0];
                pick_cnt_s  = slot_cnt_r[0];
            end
            2'd1: begin
                pick_tone_s = slot_tone_r[1];
                pick_cnt_s  = slot_cnt_r[1];
            end
            2'd2: begin
                pick_tone_s = slot_tone_r[2];
                pick_cnt_s  = slot_cnt_r[2];
            end
            default: begin
                pick_tone_s = 2'b00;
                pick_cnt_s  = 2'b01;
            end
        endcase
    end

    // Next-state, next-output and pending-flag logic of the burst sequencer.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        beeps_s = beeps_r;
        tone_s  = tone_r;
        grant_s = 3'b000;
        case (state_r)
            ST_IDLE: begin
                if (pend_r != 3'b000) begin
                    state_s = ST_ON;
                    tick_s  = '0;
                    tone_s  = pick_tone_s;
                    beeps_s = pick_cnt_s;
                    grant_s = 3'b001 << pick_s;
                end else begin
                    tick_s = '0;
                end
            end
            ST_ON: begin
                if (tick_r == ON_LAST) begin
                    tick_s = '0;
                    if (beeps_r > 2'd1) begin
                        beeps_s = beeps_r - 2'd1;
                        state_s = ST_OFF;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            ST_OFF: begin
                if (tick_r == OFF_LAST) begin
                    tick_s  = '0;
                    state_s = ST_ON;
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            ST_GAP: begin
                if (tick_r == GAP_LAST) begin
                    tick_s  = '0;
                    state_s = ST_IDLE;
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                tick_s  = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        bu_s   = (state_s == ST_ON) ? tone_s : 2'b00;
        busy_s = (state_s != ST_IDLE);

        // A strobe in the grant cycle wins over the grant's clear.
        pend_s = pend_r & ~grant_s;
        for (int i = 0; i < 3; i++) begin
            if (Req[i]) begin
                pend_s[i] = (ReqTone[2*i +: 2] != 2'b00);
            end else begin
                pend_s[i] = pend_s[i];
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
            tick_r  <= '0;
            beeps_r <= 2'b00;
            tone_r  <= 2'b00;
            pend_r  <= 3'b000;
            grant_r <= 3'b000;
            bu_r    <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            beeps_r <= beeps_s;
            tone_r  <= tone_s;
            pend_r  <= pend_s;
            grant_r <= grant_s;
            bu_r    <= bu_s;
            busy_r  <= busy_s;
        end
    end

    // Per-slot capture of tone and count on a non-cancelling strobe.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 3; i++) begin
                slot_tone_r[i] <= 2'b00;
                slot_cnt_r[i]  <= 2'b00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (Req[i] && (ReqTone[2*i +: 2] != 2'b00)) begin
                    slot_tone_r[i] <= ReqTone[2*i +: 2];
                    slot_cnt_r[i]  <= map_cnt(ReqCnt[2*i +: 2]);
                end else begin
                    slot_tone_r[i] <= slot_tone_r[i];
                    slot_cnt_r[i]  <= slot_cnt_r[i];
                end
            end
        end
    end

    assign Bu    = bu_r;
    assign Busy  = busy_r;
    assign Grant = grant_r;
    assign Pend  = pend_r;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Testbench for buzzer_scheduler: directed scenarios plus random traffic,
// every cycle compared against a burst-timeline reference model.
module tb_buzzer_scheduler;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int GAP = 6;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [2:0] Req = 3'b000;
    logic [5:0] ReqTone = 6'b0;
    logic [5:0] ReqCnt = 6'b0;
    logic [1:0] Bu;
    logic       Busy;
    logic [2:0] Grant;
    logic [2:0] Pend;

    buzzer_scheduler #(.ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqTone(ReqTone), .ReqCnt(ReqCnt),
        .Bu(Bu), .Busy(Busy), .Grant(Grant), .Pend(Pend)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t = 0;
    logic seen_g2 = 1'b0;

    // Reference model: pending flags, slot contents and the current burst
    // described by its start cycle, length and tone.
    logic [2:0] m_pend = 3'b000;
    logic [1:0] m_tone [3];
    int         m_cnt  [3];
    logic       b_active = 1'b0;
    int         b_start = 0;
    int         b_len = 0;
    logic [1:0] b_tone = 2'b00;
    logic [2:0] e_grant = 3'b000;
    logic [1:0] e_bu = 2'b00;
    logic       e_busy = 1'b0;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d t=%0d observed=%b expected=%b", tag, cyc, t, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic idle;
        int   k;
        int   o;
        if (Rst) begin
            m_pend   = 3'b000;
            b_active = 1'b0;
            e_grant  = 3'b000;
        end else begin
            idle    = !b_active || (cyc >= b_start + b_len);
            e_grant = 3'b000;
            if (idle && m_pend != 3'b000) begin
                k        = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                b_active = 1'b1;
                b_start  = cyc + 1;
                b_len    = m_cnt[k] * ON + (m_cnt[k] - 1) * OFF + GAP;
                b_tone   = m_tone[k];
                e_grant  = 3'(1 << k);
                m_pend[k] = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (Req[i]) begin
                    if (ReqTone[2*i +: 2] != 2'b00) begin
                        m_pend[i] = 1'b1;
                        m_tone[i] = ReqTone[2*i +: 2];
                        m_cnt[i]  = (ReqCnt[2*i +: 2] == 2'b00) ? 1 : int'(ReqCnt[2*i +: 2]);
                    end else begin
                        m_pend[i] = 1'b0;
                    end
                end
            end
        end
        cyc++;
        e_busy = b_active && (cyc >= b_start) && (cyc < b_start + b_len);
        o = cyc - b_start;
        e_bu = (e_busy && (o < b_len - GAP) && ((o % (ON + OFF)) < ON)) ? b_tone : 2'b00;
    endtask

    // One clock: update model at the edge, compare all outputs, drop strobes.
    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        t++;
        check("m_bu", {1'b0, Bu}, {1'b0, e_bu});
        check("m_busy", {2'b00, Busy}, {2'b00, e_busy});
        check("m_grant", Grant, e_grant);
        check("m_pend", Pend, m_pend);
        if (Grant == 3'b100) seen_g2 = 1'b1;
        Req = 3'b000;
    endtask

    task automatic goto(input int tgt);
        while (t < tgt) step();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_tone[i] = 2'b00;
            m_cnt[i]  = 1;
        end
        #2;
        do_reset();
        check("rst_bu", {1'b0, Bu}, 3'b000);
        check("rst_busy", {2'b00, Busy}, 3'b000);
        check("rst_pend", Pend, 3'b000);

        // Single beep
        t = 0; Req = 3'b001; ReqTone = 6'b00_00_01; ReqCnt = 6'b00_00_01;
        goto(1);  check("sb_pend1", Pend, 3'b001);
        goto(2);  check("sb_grant2", Grant, 3'b001); check("sb_bu2", {1'b0, Bu}, 3'b001);
        goto(5);  check("sb_bu5", {1'b0, Bu}, 3'b001);
        goto(6);  check("sb_bu6", {1'b0, Bu}, 3'b000); check("sb_busy6", {2'b00, Busy}, 3'b001);
        goto(11); check("sb_busy11", {2'b00, Busy}, 3'b001);
        goto(12); check("sb_busy12", {2'b00, Busy}, 3'b000);
        goto(14);

        // Triple beep
        t = 0; Req = 3'b001; ReqTone = 6'b00_00_11; ReqCnt = 6'b00_00_11;
        goto(2);  check("tb_bu2", {1'b0, Bu}, 3'b011);
        goto(6);  check("tb_bu6", {1'b0, Bu}, 3'b000);
        goto(8);  check("tb_bu8", {1'b0, Bu}, 3'b011);
        goto(13); check("tb_bu13", {1'b0, Bu}, 3'b000);
        goto(17); check("tb_bu17", {1'b0, Bu}, 3'b011);
        goto(18); check("tb_gap18", {1'b0, Bu, Busy}, 3'b001);
        goto(23); check("tb_busy23", {2'b00, Busy}, 3'b001);
        goto(24); check("tb_idle24", {2'b00, Busy}, 3'b000);
        goto(26);

        // Priority
        t = 0; Req = 3'b111; ReqTone = 6'b11_10_01; ReqCnt = 6'b01_01_01;
        goto(1);  check("pr_pend1", Pend, 3'b111);
        goto(2);  check("pr_g2", Grant, 3'b001); check("pr_p2", Pend, 3'b110); check("pr_bu2", {1'b0, Bu}, 3'b001);
        goto(13); check("pr_g13", Grant, 3'b010); check("pr_p13", Pend, 3'b100); check("pr_bu13", {1'b0, Bu}, 3'b010);
        goto(24); check("pr_g24", Grant, 3'b100); check("pr_p24", Pend, 3'b000); check("pr_bu24", {1'b0, Bu}, 3'b011);
        goto(36);

        // Re-request during ON
        t = 0; Req = 3'b001; ReqTone = 6'b00_00_01; ReqCnt = 6'b00_00_01;
        goto(3); Req = 3'b001; ReqTone = 6'b00_00_10; ReqCnt = 6'b00_00_10;
        goto(4);  check("rr_pend4", Pend, 3'b001); check("rr_bu4", {1'b0, Bu}, 3'b001);
        goto(13); check("rr_g13", Grant, 3'b001); check("rr_bu13", {1'b0, Bu}, 3'b010);
        goto(40);

        // Cancel of a pending slot, and count zero
        seen_g2 = 1'b0;
        t = 0; Req = 3'b110; ReqTone = 6'b11_01_00; ReqCnt = 6'b01_00_00;
        goto(2);  check("cn_g2", Grant, 3'b010); check("cn_p2", Pend, 3'b100);
        Req = 3'b100; ReqTone = 6'b00_00_00;
        goto(3);  check("cn_p3", Pend, 3'b000);
        goto(6);  check("cz_bu6", {1'b0, Bu, Busy}, 3'b001);
        goto(12); check("cz_busy12", {2'b00, Busy}, 3'b000);
        goto(30); check("cn_nog2", {2'b00, seen_g2}, 3'b000);

        // Reset mid-beep, then a fresh single beep
        t = 0; Req = 3'b001; ReqTone = 6'b00_00_01; ReqCnt = 6'b00_00_11;
        goto(2); Req = 3'b110; ReqTone = 6'b10_11_01;
        goto(4); check("rm_pend4", Pend, 3'b110); check("rm_bu4", {1'b0, Bu}, 3'b001);
        Rst = 1'b1;
        goto(5); Rst = 1'b0;
        check("rm_bu5", {1'b0, Bu}, 3'b000); check("rm_busy5", {2'b00, Busy}, 3'b000);
        check("rm_pend5", Pend, 3'b000); check("rm_grant5", Grant, 3'b000);
        t = 0; Req = 3'b001; ReqTone = 6'b00_00_01; ReqCnt = 6'b00_00_01;
        goto(1);  check("rs_pend1", Pend, 3'b001);
        goto(2);  check("rs_grant2", Grant, 3'b001); check("rs_bu2", {1'b0, Bu}, 3'b001);
        goto(12); check("rs_busy12", {2'b00, Busy}, 3'b000);
        goto(14);

        // Strobe colliding with the grant of the same slot
        t = 0; Req = 3'b001; ReqTone = 6'b00_00_01; ReqCnt = 6'b00_00_01;
        goto(1); Req = 3'b001; ReqTone = 6'b00_00_10;
        goto(2);  check("co_g2", Grant, 3'b001); check("co_p2", Pend, 3'b001); check("co_bu2", {1'b0, Bu}, 3'b001);
        goto(13); check("co_g13", Grant, 3'b001); check("co_bu13", {1'b0, Bu}, 3'b010);
        goto(26);

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 3; b++) Req[b] = ($urandom_range(0, 11) == 0);
            ReqTone = 6'($urandom);
            ReqCnt  = 6'($urandom);
            Rst     = ($urandom_range(0, 199) == 0);
            step();
        end
        Rst = 1'b0;
        goto(t + 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
